// File: rtl/sap_control_sequencer_pkg.sv
// SAP-1 sequencer shared types: T-state ring encoding, opcodes, control-word constants, decoder.
// Latency: n/a (types and a combinational decode function only).
// Backpressure: n/a.
package sap_control_sequencer_pkg;

    // Control word bit order: cp ep lm_n ce_n li_n ei_n la_n ea su eu lb_n lo_n (bit 11 .. bit 0)
    localparam int CW_W = 12;

    // One-hot T-state ring; T1 is bit 0 so rotation is a left shift
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } STATE_t;

    typedef enum logic [3:0] {
        LDA = 4'h0,
        ADD = 4'h1,
        SUB = 4'h2,
        OUT = 4'hE,
        HLT = 4'hF
    } OPCODE_t;

    // Idle: every active-low pin high, every active-high pin low
    localparam logic [CW_W-1:0] CW_IDLE = 12'h3E3;
    localparam logic [CW_W-1:0] CW_T1   = 12'h5E3;  // EP, LM_n: PC -> MAR
    localparam logic [CW_W-1:0] CW_T2   = 12'hBE3;  // CP: increment PC
    localparam logic [CW_W-1:0] CW_T3   = 12'h263;  // CE_n, LI_n: RAM -> IR

    // Control word for a T-state / opcode pair; unknown opcodes execute as NOP
    function automatic logic [CW_W-1:0] cw_decode(input STATE_t t, input OPCODE_t op);
        logic [CW_W-1:0] cw;
        cw = CW_IDLE;
        case (t)
            T1: cw = CW_T1;
            T2: cw = CW_T2;
            T3: cw = CW_T3;
            T4: begin
                case (op)
                    LDA, ADD, SUB: cw = 12'h1A3;
                    OUT:           cw = 12'h3F2;
                    default:       cw = CW_IDLE;
                endcase
            end
            T5: begin
                case (op)
                    LDA:      cw = 12'h2C3;
                    ADD, SUB: cw = 12'h2E1;
                    default:  cw = CW_IDLE;
                endcase
            end
            T6: begin
                case (op)
                    ADD:     cw = 12'h3C7;
                    SUB:     cw = 12'h3CF;
                    default: cw = CW_IDLE;
                endcase
            end
            default: cw = CW_IDLE;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Sequencer-facing bus: opcode/mode/step in, control word and status out.
// Latency: n/a (wires only).
// Backpressure: none; step is a level request, edge detected inside the sequencer.
interface sap_control_sequencer_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] ir_opcode;
    logic           run;
    logic           step;
    logic [11:0]    con;
    logic [5:0]     tstate;
    logic           halted;
    logic           instr_done;

    modport master (
        output ir_opcode, run, step,
        input  con, tstate, halted, instr_done
    );

    modport slave (
        input  ir_opcode, run, step,
        output con, tstate, halted, instr_done
    );
endinterface

// File: rtl/sap_control_sequencer_ring_counter.sv
// One-hot T1..T6 ring counter with advance, force-to-T1, freeze and self-correction.
// Latency: state changes on the clock edge after the controls are presented.
// Backpressure: freeze holds the ring; an illegal (non one-hot) value always returns to T1.
module sap_control_sequencer_ring_counter
    import sap_control_sequencer_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   advance,
    input  logic   force_t1,
    input  logic   freeze,
    output STATE_t tstate
);
    STATE_t     state_q;
    STATE_t     state_d;
    logic [5:0] raw;
    logic       legal;

    // State register; reset lands on T1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= T1;
        else        state_q <= state_d;
    end

    // Next state: corruption recovery beats freeze, freeze beats advance
    always_comb begin
        state_d = state_q;
        raw     = state_q;
        legal   = (raw != 6'd0) && ((raw & (raw - 6'd1)) == 6'd0);
        if (!legal) begin
            state_d = T1;
        end else if (freeze) begin
            state_d = state_q;
        end else if (advance) begin
            state_d = force_t1 ? T1 : STATE_t'({raw[4:0], raw[5]});
        end
    end

    assign tstate = state_q;
endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: ring counter + opcode decode -> 12-bit control word, with step/halt.
// Latency: con/instr_done are combinational from tstate/opcode; a step edge advances one cycle later.
// Backpressure: run=0 holds the ring between step edges; HLT freezes it at T4 until reset.
module sap_control_sequencer
    import sap_control_sequencer_pkg::*;
#(
    parameter bit SHORT_CYCLE = 1'b0,
    parameter int OPW         = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sap_control_sequencer_if.slave  bus
);
    logic [OPW-1:0] opcode_raw;
    OPCODE_t        op;
    STATE_t         tstate;
    STATE_t         last_t;
    logic           step_q;
    logic           step_edge_q;
    logic           halted_q;
    logic           hlt_now;
    logic           done_c;
    logic           advance;
    logic           freeze;

    assign opcode_raw = bus.ir_opcode;

    // Step edge detector and sticky halt flag; edges seen in free-run are dropped so a
    // step held across a run->step switch cannot add an extra advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= 1'b0;
            step_edge_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            step_q      <= bus.step;
            step_edge_q <= bus.step & ~step_q & ~bus.run;
            if (hlt_now) halted_q <= 1'b1;
        end
    end

    // Opcode view, instruction length, ring controls and control-word decode
    always_comb begin
        op      = OPCODE_t'(opcode_raw[3:0]);
        last_t  = T6;
        if (SHORT_CYCLE) begin
            case (op)
                LDA:      last_t = T5;
                ADD, SUB: last_t = T6;
                default:  last_t = T4;
            endcase
        end
        hlt_now = (tstate == T4) && (op == HLT);
        done_c  = (tstate == last_t) && (op != HLT) && !halted_q;
        advance = bus.run | step_edge_q;
        freeze  = halted_q | hlt_now;
        bus.con = halted_q ? CW_IDLE : cw_decode(tstate, op);
    end

    sap_control_sequencer_ring_counter u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (advance),
        .force_t1 (done_c),
        .freeze   (freeze),
        .tstate   (tstate)
    );

    assign bus.tstate     = tstate;
    assign bus.halted     = halted_q;
    assign bus.instr_done = done_c;
endmodule
